spi_burst_memory: RTL and testbench



---
 rtl/spi_burst_memory.sv | 199 +++++++++++++++++++
 tb/tb_spi_burst_memory.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_memory.sv
`timescale 1ns/1ps
// SPI slave memory of 2^ADDR_W x DATA_W words. Supports all four SPI modes and bursts with address auto-increment and wrap.
// Pins are resynchronised into clk, and MISO is released (Z) whenever the block is not in a read data phase.
module spi_burst_memory #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_pin,
   input  logic       cs_pin,
   input  logic       mosi_pin,
   output logic       miso_pin,
   output logic       miso_oe,
   output logic [3:0] leds
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int SH_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
   localparam int CNT_W = $clog2(SH_W);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic SCLK_IDLE   = (CPOL != 0);
   localparam logic SAMPLE_RISE = (CPOL == CPHA);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CMD   = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_READ  = 2'd3;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
   logic                   sclk_prev_q, cs_prev_q, armed_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic                   sample_pulse, shift_pulse;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SH_W-1:0]   shift_q, shift_d, shift_in;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
   logic              miso_oe_q, miso_oe_d;
   logic              miso_q, miso_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_dat_q, wr_dat_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         fill_q      <= '0;
         sclk_prev_q <= SCLK_IDLE;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
         fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s         = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise    = sclk_s & ~sclk_prev_q;
   assign sclk_fall    = ~sclk_s & sclk_prev_q;
   assign cs_rise      = cs_s & ~cs_prev_q;
   assign cs_fall      = ~cs_s & cs_prev_q;
   assign sample_pulse = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign shift_pulse  = SAMPLE_RISE ? sclk_fall : sclk_rise;
   assign shift_in     = {shift_q[SH_W-2:0], mosi_s};
   assign addr_inc     = addr_q + ADDR_W'(1);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      miso_oe_d = miso_oe_q;
      miso_d    = miso_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_dat_d  = wr_dat_q;
      if (cs_rise) begin
         // A frame cut short by cs is dropped here, before any commit.
         state_d   = ST_IDLE;
         miso_oe_d = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall && armed_q) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end
            end
            ST_CMD: begin
               if (sample_pulse) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == CMD_LAST) begin
                     bit_cnt_d = '0;
                     addr_d    = shift_q[ADDR_W-1:0];
                     if (mosi_s) begin
                        state_d   = ST_READ;
                        shift_d   = SH_W'(mem_q[shift_q[ADDR_W-1:0]]);
                        miso_oe_d = 1'b1;
                     end else begin
                        state_d = ST_WRITE;
                     end
                  end
               end
            end
            ST_WRITE: begin
               if (sample_pulse) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == DATA_LAST) begin
                     bit_cnt_d = '0;
                     wr_en_d   = 1'b1;
                     wr_addr_d = addr_q;
                     wr_dat_d  = shift_in[DATA_W-1:0];
                     addr_d    = addr_inc;
                  end
               end
            end
            ST_READ: begin
               if (shift_pulse) begin
                  miso_d  = shift_q[DATA_W-1];
                  shift_d = shift_q << 1;
               end else if (sample_pulse) begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == DATA_LAST) begin
                     // Preload the next word so a burst continues without a gap.
                     bit_cnt_d = '0;
                     addr_d    = addr_inc;
                     shift_d   = SH_W'(mem_q[addr_inc]);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         miso_oe_q <= 1'b0;
         miso_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_dat_q  <= '0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         miso_oe_q <= miso_oe_d;
         miso_q    <= miso_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_dat_q  <= wr_dat_d;
         // Only a cs high seen from a real pin sample arms framing, so a low cs at reset release is ignored.
         armed_q   <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_q) begin
         mem_q[wr_addr_q] <= wr_dat_q;
      end
   end

   always_comb begin
      case (state_q)
         ST_IDLE:  leds = 4'b0001;
         ST_CMD:   leds = 4'b0010;
         ST_WRITE: leds = 4'b0100;
         default:  leds = 4'b1000;
      endcase
   end

   assign miso_oe  = miso_oe_q;
   assign miso_pin = miso_oe_q ? miso_q : 1'bz;

endmodule

// File: tb/tb_spi_burst_memory.sv
`timescale 1ns/1ps
// Directed bench: five instances (four SPI modes at 8/7, one at 16/4) driven by a bit-level SPI master.
module tb_spi_burst_memory;
   localparam int HALF = 80;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] sclk_v, cs_v, mosi_v;
   wire        miso0, miso1, miso2, miso3, miso4;
   wire        oe0, oe1, oe2, oe3, oe4;
   wire [3:0]  leds0, leds1, leds2, leds3, leds4;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] rd_buf [4];

   always #5 clk = ~clk;

   spi_burst_memory #(.CPOL(0), .CPHA(0)) u_m0 (.clk(clk), .rst_n(rst_n), .sclk_pin(sclk_v[0]), .cs_pin(cs_v[0]),
      .mosi_pin(mosi_v[0]), .miso_pin(miso0), .miso_oe(oe0), .leds(leds0));
   spi_burst_memory #(.CPOL(0), .CPHA(1)) u_m1 (.clk(clk), .rst_n(rst_n), .sclk_pin(sclk_v[1]), .cs_pin(cs_v[1]),
      .mosi_pin(mosi_v[1]), .miso_pin(miso1), .miso_oe(oe1), .leds(leds1));
   spi_burst_memory #(.CPOL(1), .CPHA(0)) u_m2 (.clk(clk), .rst_n(rst_n), .sclk_pin(sclk_v[2]), .cs_pin(cs_v[2]),
      .mosi_pin(mosi_v[2]), .miso_pin(miso2), .miso_oe(oe2), .leds(leds2));
   spi_burst_memory #(.CPOL(1), .CPHA(1)) u_m3 (.clk(clk), .rst_n(rst_n), .sclk_pin(sclk_v[3]), .cs_pin(cs_v[3]),
      .mosi_pin(mosi_v[3]), .miso_pin(miso3), .miso_oe(oe3), .leds(leds3));
   spi_burst_memory #(.DATA_W(16), .ADDR_W(4)) u_m4 (.clk(clk), .rst_n(rst_n), .sclk_pin(sclk_v[4]), .cs_pin(cs_v[4]),
      .mosi_pin(mosi_v[4]), .miso_pin(miso4), .miso_oe(oe4), .leds(leds4));

   function automatic logic cpol_of(input int idx);
      return (idx == 2 || idx == 3);
   endfunction

   function automatic logic cpha_of(input int idx);
      return (idx == 1 || idx == 3);
   endfunction

   function automatic logic miso_of(input int idx);
      case (idx)
         0: return miso0;
         1: return miso1;
         2: return miso2;
         3: return miso3;
         default: return miso4;
      endcase
   endfunction

   function automatic logic oe_of(input int idx);
      case (idx)
         0: return oe0;
         1: return oe1;
         2: return oe2;
         3: return oe3;
         default: return oe4;
      endcase
   endfunction

   function automatic logic [3:0] leds_of(input int idx);
      case (idx)
         0: return leds0;
         1: return leds1;
         2: return leds2;
         3: return leds3;
         default: return leds4;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // n bits MSB first; master samples MISO on the same edge the slave samples MOSI.
   task automatic spi_bits(input int idx, input int n, input logic [15:0] dout, output logic [15:0] din);
      logic cpol, cpha;
      cpol = cpol_of(idx);
      cpha = cpha_of(idx);
      din  = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (!cpha) begin
            mosi_v[idx] = dout[i];
            #HALF;
            din = {din[14:0], miso_of(idx)};
            sclk_v[idx] = ~cpol;
            #HALF;
            sclk_v[idx] = cpol;
         end else begin
            sclk_v[idx] = ~cpol;
            mosi_v[idx] = dout[i];
            #HALF;
            din = {din[14:0], miso_of(idx)};
            sclk_v[idx] = cpol;
            #HALF;
         end
      end
   endtask

   task automatic cs_lo(input int idx);
      cs_v[idx] = 1'b0;
      #HALF;
   endtask

   task automatic cs_hi(input int idx);
      #HALF;
      cs_v[idx] = 1'b1;
      #(4 * HALF);
   endtask

   task automatic do_write(input string tag, input int idx, input int cbits, input logic [15:0] cmd, input int dw,
                           input int n, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
      logic [15:0] rx;
      logic [15:0] w;
      cs_lo(idx);
      spi_bits(idx, cbits, cmd, rx);
      for (int i = 0; i < n; i++) begin
         w = (i == 0) ? w0 : (i == 1) ? w1 : w2;
         spi_bits(idx, dw, w, rx);
      end
      check_val({tag, "_wr_leds"}, 32'(leds_of(idx)), 32'h4);
      check_val({tag, "_wr_oe"}, 32'(oe_of(idx)), 32'h0);
      cs_hi(idx);
      check_val({tag, "_wr_idle"}, 32'(leds_of(idx)), 32'h1);
   endtask

   task automatic do_read(input string tag, input int idx, input int cbits, input logic [15:0] cmd, input int dw,
                          input int n);
      logic [15:0] rx;
      cs_lo(idx);
      spi_bits(idx, cbits, cmd, rx);
      for (int i = 0; i < n; i++) begin
         spi_bits(idx, dw, 16'h0000, rx);
         rd_buf[i] = rx;
      end
      check_val({tag, "_rd_oe"}, 32'(oe_of(idx)), 32'h1);
      check_val({tag, "_rd_leds"}, 32'(leds_of(idx)), 32'h8);
      cs_hi(idx);
      check_val({tag, "_rd_oe_off"}, 32'(oe_of(idx)), 32'h0);
   endtask

   initial begin
      logic [15:0] rx;
      rst_n  = 1'b0;
      cs_v   = 5'b11111;
      mosi_v = 5'b00000;
      sclk_v = 5'b01100;
      repeat (3) @(negedge clk);
      check_val("rst_leds0", 32'(leds0), 32'h1);
      check_val("rst_oe0", 32'(oe0), 32'h0);
      check_val("rst_leds4", 32'(leds4), 32'h1);
      check_val("rst_oe4", 32'(oe4), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single write/read, mode 0: 0x24 = addr 0x12 write, 0x25 = addr 0x12 read
      do_write("single", 0, 8, 16'h24, 8, 1, 16'hA5, 16'h0, 16'h0);
      do_read("single", 0, 8, 16'h25, 8, 1);
      check_val("single_data", 32'(rd_buf[0][7:0]), 32'hA5);

      // Burst write from 0x7F wraps to 0x00, 0x01
      do_write("burst", 0, 8, 16'hFE, 8, 3, 16'h11, 16'h22, 16'h33);
      do_read("burst", 0, 8, 16'hFF, 8, 3);
      check_val("burst_w0", 32'(rd_buf[0][7:0]), 32'h11);
      check_val("burst_w1", 32'(rd_buf[1][7:0]), 32'h22);
      check_val("burst_w2", 32'(rd_buf[2][7:0]), 32'h33);
      do_read("wrap0", 0, 8, 16'h01, 8, 1);
      check_val("wrap_addr0", 32'(rd_buf[0][7:0]), 32'h22);
      do_read("wrap1", 0, 8, 16'h03, 8, 1);
      check_val("wrap_addr1", 32'(rd_buf[0][7:0]), 32'h33);

      // All four modes: 0x3C to addr 0x05
      for (int m = 0; m < 4; m++) begin
         do_write("mode", m, 8, 16'h0A, 8, 1, 16'h3C, 16'h0, 16'h0);
         do_read("mode", m, 8, 16'h0B, 8, 1);
         check_val($sformatf("mode%0d_data", m), 32'(rd_buf[0][7:0]), 32'h3C);
      end

      // Abort after 5 data bits: no write, IDLE within SYNC_STAGES+2 clk
      cs_lo(0);
      spi_bits(0, 8, 16'h0A, rx);
      spi_bits(0, 5, 16'h1F, rx);
      check_val("abort_in_write", 32'(leds0), 32'h4);
      cs_v[0] = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_val("abort_idle", 32'(leds0), 32'h1);
      #(4 * HALF);
      do_read("abort", 0, 8, 16'h0B, 8, 1);
      check_val("abort_mem_kept", 32'(rd_buf[0][7:0]), 32'h3C);
      do_write("after_abort", 0, 8, 16'h0A, 8, 1, 16'h5A, 16'h0, 16'h0);
      do_read("after_abort", 0, 8, 16'h0B, 8, 1);
      check_val("after_abort_data", 32'(rd_buf[0][7:0]), 32'h5A);

      // Reset pulse during the 3rd read bit with cs held low
      cs_lo(0);
      spi_bits(0, 8, 16'h0B, rx);
      spi_bits(0, 2, 16'h0, rx);
      mosi_v[0] = 1'b0;
      #HALF;
      sclk_v[0] = 1'b1;
      #20;
      rst_n = 1'b0;
      #10;
      rst_n = 1'b1;
      check_val("rstmid_oe", 32'(oe0), 32'h0);
      check_val("rstmid_leds", 32'(leds0), 32'h1);
      #(HALF - 30);
      sclk_v[0] = 1'b0;
      spi_bits(0, 8, 16'h25, rx);
      check_val("rstmid_still_idle", 32'(leds0), 32'h1);
      check_val("rstmid_still_oe", 32'(oe0), 32'h0);
      cs_hi(0);
      do_read("post_rst", 0, 8, 16'h0B, 8, 1);
      check_val("post_rst_data", 32'(rd_buf[0][7:0]), 32'h5A);

      // DATA_W=16, ADDR_W=4: 0x1E = addr 0xF write, 0x1F = addr 0xF read
      do_write("gen", 4, 5, 16'h1E, 16, 2, 16'hBEEF, 16'h1234, 16'h0);
      do_read("gen", 4, 5, 16'h1F, 16, 2);
      check_val("gen_w0", 32'(rd_buf[0]), 32'hBEEF);
      check_val("gen_w1", 32'(rd_buf[1]), 32'h1234);
      do_read("gen_a0", 4, 5, 16'h01, 16, 1);
      check_val("gen_addr0", 32'(rd_buf[0]), 32'h1234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
